couche_substitution_serial: RTL and testbench

Sequential, parametrised successor to the combinational ASCON substitution layer. It applies the 5-bit ASCON S-box to the 64 bit-columns of a 320-bit `type_state`, processing `LANES` columns per clock, so area can be traded against latency. It sits between the constant-addition and linear-diffusion layers of the permutation datapath and is controlled by a start/done handshake from the permutation FSM.

---
 rtl/ascon_pack.sv | 32 +++
 rtl/couche_substitution_serial_sbox_lane.sv | 24 ++
 rtl/couche_substitution_serial.sv | 150 +++++++++++++++
 tb/tb_couche_substitution_serial.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_pack.sv
// Shared ASCON types: 320-bit state, 5-bit S-box tables and the substitution FSM encoding.
// Latency: none (types and constants only).
// Backpressure: none. Optional macro ASCON_SUB_INV_EN adds the inverse S-box table.
package ascon_pack;

   // Five 64-bit words; index w selects word w, word 0 is the MSB of every S-box column.
   typedef logic [4:0][63:0] type_state;

   localparam logic [4:0] SBOX [32] = '{
      5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
      5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
      5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
      5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
   };

`ifdef ASCON_SUB_INV_EN
   // Exact inverse permutation of SBOX: SBOX_INV[SBOX[x]] == x.
   localparam logic [4:0] SBOX_INV [32] = '{
      5'h14, 5'h1a, 5'h07, 5'h0d, 5'h00, 5'h09, 5'h0e, 5'h12,
      5'h0a, 5'h06, 5'h1d, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1e,
      5'h18, 5'h16, 5'h0b, 5'h11, 5'h03, 5'h05, 5'h1c, 5'h1f,
      5'h17, 5'h1b, 5'h04, 5'h08, 5'h0f, 5'h0c, 5'h10, 5'h02
   };
`endif

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } type_sub_fsm;

endpackage

// File: rtl/couche_substitution_serial_sbox_lane.sv
// One ASCON S-box lane: 5-bit column in, substituted 5-bit column out (optionally inverse).
// Latency: purely combinational, zero cycles.
// Backpressure: none. The inv input exists only when ASCON_SUB_INV_EN is defined.
module sbox_lane
   import ascon_pack::*;
(
   input  logic [4:0] col,
`ifdef ASCON_SUB_INV_EN
   input  logic       inv,
`endif
   output logic [4:0] col_sub
);

   // Table lookup; inverse table overrides the forward one when selected.
   always_comb begin
      col_sub = SBOX[col];
`ifdef ASCON_SUB_INV_EN
      if (inv) begin
         col_sub = SBOX_INV[col];
      end
`endif
   end

endmodule

// File: rtl/couche_substitution_serial.sv
// Serial ASCON substitution layer: LANES S-box columns per clock over a 320-bit state.
// Latency: 64/LANES + 1 clocks from accepted start to first done_o cycle; all outputs registered.
// Backpressure: start_i only accepted in IDLE or DONE, ignored in RUN. Macro ASCON_SUB_INV_EN adds mode_i.
module couche_substitution_serial
   import ascon_pack::*;
#(
   parameter int LANES = 8
)(
   input  logic      clock_i,
   input  logic      reset_i,
   input  logic      start_i,
   input  type_state sub_i,
`ifdef ASCON_SUB_INV_EN
   input  logic      mode_i,
`endif
   output type_state sub_o,
   output logic      busy_o,
   output logic      done_o
);

   localparam int N  = 64 / LANES;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 &&
       LANES != 16 && LANES != 32 && LANES != 64) begin : g_bad_lanes
      $error("couche_substitution_serial: LANES must be one of 1,2,4,8,16,32,64");
   end

   type_sub_fsm            state_q;
   type_sub_fsm            state_d;
   logic [CW-1:0]          cnt_q;
   type_state              work_q;
   type_state              work_step;
   logic                   load;
   logic                   step;
   logic                   last;
   logic                   busy_q;
   logic                   done_q;
   logic [5:0]             base;
   logic [LANES-1:0][4:0]  lane_in;
   logic [LANES-1:0][4:0]  lane_out;
`ifdef ASCON_SUB_INV_EN
   logic                   mode_q;
`endif

   assign last = (cnt_q == CW'(N - 1));
   assign base = 6'(int'(cnt_q) * LANES);

   // Next-state decode: start reloads from IDLE or DONE, RUN walks the chunks and ignores start.
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      step    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               load    = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            step = 1'b1;
            if (last) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (start_i) begin
               load    = 1'b1;
               state_d = RUN;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, chunk counter, work register and registered status flags.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         work_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= (state_d == RUN);
         done_q  <= (state_d == DONE);
         if (load) begin
            work_q <= sub_i;
            cnt_q  <= '0;
         end else if (step) begin
            work_q <= work_step;
            cnt_q  <= last ? '0 : cnt_q + 1'b1;
         end
      end
   end

`ifdef ASCON_SUB_INV_EN
   // Direction is latched with the state so a change on mode_i mid-run has no effect.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         mode_q <= 1'b0;
      end else if (load) begin
         mode_q <= mode_i;
      end
   end
`endif

   // Gather the current chunk's columns; word 0 supplies the column MSB.
   always_comb begin
      logic [5:0] col;
      col     = '0;
      lane_in = '0;
      for (int k = 0; k < LANES; k++) begin
         col        = base + 6'(k);
         lane_in[k] = {work_q[0][col], work_q[1][col], work_q[2][col],
                       work_q[3][col], work_q[4][col]};
      end
   end

   // Scatter substituted columns back; columns outside the chunk keep their value.
   always_comb begin
      logic [5:0] col;
      col       = '0;
      work_step = work_q;
      for (int k = 0; k < LANES; k++) begin
         col = base + 6'(k);
         {work_step[0][col], work_step[1][col], work_step[2][col],
          work_step[3][col], work_step[4][col]} = lane_out[k];
      end
   end

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      sbox_lane u_lane (
         .col     (lane_in[k]),
`ifdef ASCON_SUB_INV_EN
         .inv     (mode_q),
`endif
         .col_sub (lane_out[k])
      );
   end

   assign sub_o  = work_q;
   assign busy_o = busy_q;
   assign done_o = done_q;

endmodule

// File: tb/tb_couche_substitution_serial.sv
// Self-checking bench for couche_substitution_serial with LANES = 8, 1, 64, 4 instances.
// Expected states come from an independent column-wise S-box model and are queued at start.
// Build with ASCON_SUB_INV_EN defined to also exercise the inverse direction.
module tb_couche_substitution_serial;
   import ascon_pack::*;

   localparam int ND = 4;

   logic      clk = 1'b0;
   logic      rst;
   logic      start   [ND];
   type_state sub_in  [ND];
   type_state sub_out [ND];
   logic      busy    [ND];
   logic      done    [ND];
`ifdef ASCON_SUB_INV_EN
   logic      mode    [ND];
`endif

   int        n_vec = 0;
   int        n_err = 0;
   type_state exp_q [$];
   type_state cur_in;
   bit        cur_mode;

   localparam logic [4:0] REF_SBOX [32] = '{
      5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
      5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
      5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
      5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
   };

   always #5 clk = ~clk;

   for (genvar g = 0; g < ND; g++) begin : g_dut
      couche_substitution_serial #(
         .LANES(g == 0 ? 8 : (g == 1 ? 1 : (g == 2 ? 64 : 4)))
      ) u_dut (
         .clock_i (clk),
         .reset_i (rst),
         .start_i (start[g]),
         .sub_i   (sub_in[g]),
`ifdef ASCON_SUB_INV_EN
         .mode_i  (mode[g]),
`endif
         .sub_o   (sub_out[g]),
         .busy_o  (busy[g]),
         .done_o  (done[g])
      );
   end

   function automatic int lanes_of(int g);
      return (g == 0) ? 8 : ((g == 1) ? 1 : ((g == 2) ? 64 : 4));
   endfunction

   function automatic int lat_of(int g);
      return (g == 0) ? 9 : ((g == 1) ? 65 : ((g == 2) ? 2 : 17));
   endfunction

   function automatic type_state mk(logic [63:0] w0, logic [63:0] w1, logic [63:0] w2,
                                    logic [63:0] w3, logic [63:0] w4);
      type_state s;
      s[0] = w0; s[1] = w1; s[2] = w2; s[3] = w3; s[4] = w4;
      return s;
   endfunction

   function automatic type_state rand_state();
      type_state s;
      for (int w = 0; w < 5; w++) s[w] = {$urandom, $urandom};
      return s;
   endfunction

   function automatic logic [4:0] ref_box(logic [4:0] x, bit inv);
      if (!inv) return REF_SBOX[x];
      for (int v = 0; v < 32; v++) begin
         if (REF_SBOX[v] == x) return 5'(v);
      end
      return 5'h00;
   endfunction

   // Substitute columns 0..ncols-1, leave the rest untouched.
   function automatic type_state ref_sub(type_state s, int ncols, bit inv);
      type_state  r;
      logic [4:0] c;
      r = s;
      for (int j = 0; j < ncols; j++) begin
         c = {s[0][j], s[1][j], s[2][j], s[3][j], s[4][j]};
         c = ref_box(c, inv);
         {r[0][j], r[1][j], r[2][j], r[3][j], r[4][j]} = c;
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [319:0] got, input logic [319:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called on a negedge; returns on the negedge after the accepted start edge.
   task automatic start_op(input int g, input type_state s, input bit m, input type_state exp);
      sub_in[g] = s;
      start[g]  = 1'b1;
`ifdef ASCON_SUB_INV_EN
      mode[g]   = m;
`endif
      cur_in    = s;
      cur_mode  = m;
      @(posedge clk);
      exp_q.push_back(exp);
      @(negedge clk);
      start[g] = 1'b0;
   endtask

   // Called on the negedge after the start edge; bounded wait for done, then scoreboard check.
   task automatic wait_done(input int g, input int exp_lat);
      int        cnt;
      type_state e;
      cnt = 0;
      while (!done[g] && cnt < 100) begin
         if (cnt == 0) begin
            chk("busy_run", 320'(busy[g]), 320'(1));
            chk("loaded", sub_out[g], cur_in);
         end
         if (cnt == 1) begin
            chk("partial", sub_out[g], ref_sub(cur_in, lanes_of(g), cur_mode));
         end
         @(negedge clk);
         cnt++;
      end
      chk("latency", 320'(cnt + 1), 320'(exp_lat));
      chk("done_flag", 320'(done[g]), 320'(1));
      chk("sb_depth", 320'(exp_q.size()), 320'(1));
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("result", sub_out[g], e);
      end
   endtask

   initial begin
      type_state a;
      type_state b;
      type_state r;
      type_state ones;
      ones = '1;
      rst  = 1'b1;
      for (int g = 0; g < ND; g++) begin
         start[g]  = 1'b0;
         sub_in[g] = '0;
`ifdef ASCON_SUB_INV_EN
         mode[g]   = 1'b0;
`endif
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      for (int g = 0; g < ND; g++) begin
         chk("reset_sub", sub_out[g], '0);
         chk("reset_busy", 320'(busy[g]), 320'(0));
         chk("reset_done", 320'(done[g]), 320'(0));
      end

      // All-zero state: every column 00 -> 04.
      start_op(0, '0, 1'b0, mk(64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0));
      wait_done(0, 9);

      // All-ones state on every lane count: column 1f -> 17.
      for (int g = 0; g < ND; g++) begin
         start_op(g, ones, 1'b0,
                  mk(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF,
                     64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF));
         wait_done(g, lat_of(g));
      end

      // Reference vector against the column model.
      a = mk(64'h80400c0600000000, 64'h8a55114d1cb6a9a2, 64'hbe263d4d7aecaa0f,
             64'h4ed0ec0b98c529b7, 64'hc8cddf37bcd0284a);
      start_op(0, a, 1'b0, ref_sub(a, 64, 1'b0));
      wait_done(0, 9);

      // Random states on the 8-lane and 4-lane instances.
      for (int i = 0; i < 3; i++) begin
         a = rand_state();
         start_op(0, a, 1'b0, ref_sub(a, 64, 1'b0));
         wait_done(0, 9);
         a = rand_state();
         start_op(3, a, 1'b0, ref_sub(a, 64, 1'b0));
         wait_done(3, 17);
      end

      // Reset on the third RUN edge, with a start in the same cycle that must be dropped.
      a = rand_state();
      start_op(0, a, 1'b0, ref_sub(a, 64, 1'b0));
      exp_q.delete();
      @(negedge clk);
      @(negedge clk);
      rst      = 1'b1;
      start[0] = 1'b1;
      @(negedge clk);
      rst      = 1'b0;
      start[0] = 1'b0;
      chk("midrst_sub", sub_out[0], '0);
      chk("midrst_busy", 320'(busy[0]), 320'(0));
      chk("midrst_done", 320'(done[0]), 320'(0));
      @(negedge clk);
      chk("midrst_idle", 320'(busy[0]), 320'(0));
      start_op(0, a, 1'b0, ref_sub(a, 64, 1'b0));
      wait_done(0, 9);

      // Start held through RUN with sub_i changed mid-run, then back-to-back reload from DONE.
      a = rand_state();
      b = rand_state();
      sub_in[0] = a;
      start[0]  = 1'b1;
      cur_in    = a;
      cur_mode  = 1'b0;
      @(posedge clk);
      exp_q.push_back(ref_sub(a, 64, 1'b0));
      @(negedge clk);
      sub_in[0] = b;
      wait_done(0, 9);
      cur_in = b;
      @(posedge clk);
      exp_q.push_back(ref_sub(b, 64, 1'b0));
      @(negedge clk);
      start[0] = 1'b0;
      wait_done(0, 9);

`ifdef ASCON_SUB_INV_EN
      // Forward then inverse recovers the original state.
      a = rand_state();
      r = ref_sub(a, 64, 1'b0);
      start_op(0, a, 1'b0, r);
      wait_done(0, 9);
      start_op(0, r, 1'b1, a);
      wait_done(0, 9);
      // Inverse of all-zero: every column becomes 14.
      start_op(0, '0, 1'b1, mk(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0));
      wait_done(0, 9);
`else
      r = '0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
